// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between a requester and the memory responder
interface mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding memory responder with fixed latency
// and byte/half/word loads and stores on a word-organised storage array.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        writeQ;
  logic        unsignedQ;
  logic [1:0]  sizeQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic        reqReady;
  logic        rspValid;
  logic        rspError;
  logic [31:0] rspRdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] wordIdx;
  logic [31:0]   rdWord;
  logic [7:0]    byteSel;
  logic [15:0]   halfSel;
  logic [31:0]   loadData;
  logic          accessErr;
  logic [3:0]    byteEn;
  logic [31:0]   wdLanes;
  logic          finishing;
  logic          memWrite;

  // Out-of-range addresses alias inside the array, but accessErr blocks their effect.
  assign wordIdx = addrQ[AW+1:2];
  assign rdWord  = mem[wordIdx];

  always_comb begin
    accessErr = 1'b0;
    case (sizeQ)
      2'b01:   accessErr = addrQ[0];
      2'b10:   accessErr = (addrQ[1:0] != 2'b00);
      2'b11:   accessErr = 1'b1;
      default: accessErr = 1'b0;
    endcase
    if (addrQ[31:2] >= 30'(DEPTH_WORDS)) accessErr = 1'b1;
  end

  always_comb begin
    byteSel = rdWord[7:0];
    case (addrQ[1:0])
      2'd0: byteSel = rdWord[7:0];
      2'd1: byteSel = rdWord[15:8];
      2'd2: byteSel = rdWord[23:16];
      2'd3: byteSel = rdWord[31:24];
      default: byteSel = rdWord[7:0];
    endcase
    halfSel = addrQ[1] ? rdWord[31:16] : rdWord[15:0];
    case (sizeQ)
      2'b00:   loadData = unsignedQ ? {24'b0, byteSel} : {{24{byteSel[7]}}, byteSel};
      2'b01:   loadData = unsignedQ ? {16'b0, halfSel} : {{16{halfSel[15]}}, halfSel};
      default: loadData = rdWord;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    case (sizeQ)
      2'b00: begin
        byteEn  = 4'b0001 << addrQ[1:0];
        wdLanes = {4{wdataQ[7:0]}};
      end
      2'b01: begin
        byteEn  = addrQ[1] ? 4'b1100 : 4'b0011;
        wdLanes = {2{wdataQ[15:0]}};
      end
      default: begin
        byteEn  = 4'b1111;
        wdLanes = wdataQ;
      end
    endcase
  end

  assign finishing = (state == BUSY) && (cnt == 3'd1);
  assign memWrite  = !rst && finishing && writeQ && !accessErr;

  always_ff @(posedge clk) begin
    if (memWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][i*8 +: 8] <= wdLanes[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      reqReady  <= 1'b1;
      rspValid  <= 1'b0;
      rspRdata  <= 32'd0;
      rspError  <= 1'b0;
      writeQ    <= 1'b0;
      unsignedQ <= 1'b0;
      sizeQ     <= 2'b00;
      addrQ     <= 32'd0;
      wdataQ    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            writeQ    <= bus.req_write;
            unsignedQ <= bus.req_unsigned;
            sizeQ     <= bus.req_size;
            addrQ     <= bus.req_addr;
            wdataQ    <= bus.req_wdata;
            cnt       <= 3'(LATENCY);
            reqReady  <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rspValid <= 1'b1;
            rspError <= accessErr;
            rspRdata <= (accessErr || writeQ) ? 32'd0 : loadData;
            state    <= RESP;
          end
        end
        RESP: begin
          rspValid <= 1'b0;
          reqReady <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          reqReady <= 1'b1;
          rspValid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = reqReady;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_rdata = rspRdata;
  assign bus.rsp_error = rspError;
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit storage words (power of two, 4..1024).
REQ-002 Parameter LATENCY, default 2, cycles spent in BUSY per request (1..7).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  1  request present this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 req_ready  output  1  responder can accept a request this cycle.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  32  load result, extended to 32 bits.
REQ-014 rsp_error  output  1  request rejected; qualified by rsp_valid.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and RESP only.
REQ-016 req_ready SHALL be 1 in IDLE and 0 in BUSY and RESP.
REQ-017 Acceptance SHALL occur on an edge with req_valid=1 and req_ready=1: all req_* fields captured, counter loaded with LATENCY, IDLE->BUSY.
REQ-018 Inputs outside the accepting edge SHALL be ignored; request fields changing during BUSY have no effect.
REQ-019 BUSY SHALL decrement the counter each cycle and, on the edge where it reaches 0, perform the access, register rsp_rdata/rsp_error, and go BUSY->RESP.
REQ-020 RESP SHALL assert rsp_valid for exactly one cycle, then go RESP->IDLE unconditionally.
REQ-021 rsp_valid SHALL be high in the (LATENCY+1)-th cycle after the accepting edge; back-to-back throughput SHALL be one request per LATENCY+2 cycles.
REQ-022 Error conditions: req_size=11; half with addr[0]=1; word with addr[1:0]!=00; addr[31:2] >= DEPTH_WORDS.
REQ-023 On error: no storage update, rsp_rdata=0, rsp_error=1; the request still traverses BUSY and RESP with normal timing.
REQ-024 Load: select word addr[31:2], lane addr[1:0] (byte) or addr[1] (half), little-endian; extend per req_unsigned; word ignores req_unsigned.
REQ-025 Store: write only the addressed lanes (byte: 1 lane, half: 2, word: 4); other lanes unchanged; rsp_rdata=0, rsp_error=0.
REQ-026 Storage SHALL be modified only on the BUSY->RESP edge of a non-error store.
REQ-027 Outside RESP, rsp_valid=0 and rsp_rdata/rsp_error SHALL hold their last registered values.

Reset
REQ-028 rst=1 on an edge SHALL force IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_error=0; req_ready=1 in the first cycle after reset.
REQ-029 rst has priority over acceptance and over BUSY/RESP progress.
REQ-030 Reset during BUSY SHALL discard the pending request: no storage write, no rsp_valid.
REQ-031 Reset SHALL NOT clear storage; contents are undefined until written.

Verification
REQ-032 Word round trip, LATENCY=2: store 0xDEADBEEF @0x10, then load word @0x10 -> rsp_valid 3 cycles after each acceptance, rdata=0xDEADBEEF, error=0.
REQ-033 Byte/half extension: after word 0x80FF7F01 @0x20: lb @0x23 -> 0xFFFFFF80; lbu @0x23 -> 0x00000080; lh @0x22 -> 0xFFFF80FF; lhu @0x20 -> 0x00007F01.
REQ-034 Partial store: word 0x11223344 @0x30, sb 0xAA @0x31, sh 0xBBCC @0x32 -> load word @0x30 = 0xBBCCAA44.
REQ-035 Errors: lw @0x02, lh @0x05, size=11, lw @(DEPTH_WORDS*4) -> each rsp_error=1, rdata=0; a following lw @0x00 shows storage unchanged.
REQ-036 Handshake: req_valid held high continuously -> req_ready low from acceptance through RESP; accepting edges exactly LATENCY+2 cycles apart.
REQ-037 Reset mid-op: store 0x55555555 @0x40 over prior 0x12345678, rst asserted in first BUSY cycle -> no rsp_valid; load @0x40 returns 0x12345678.
